// File: rtl/sakebi_ethernet_tx_arbiter.sv
// Round-robin frame arbiter: grants one AXI-Stream source per frame onto a
// shared Ethernet TX datapath, inserts an inter-frame gap, counts frames.
module sakebi_ethernet_tx_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned IFG_CYCLES = 12,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                            i_axis_ACLK,
    input  logic                            i_axis_ARESETn,
    input  logic [NUM_PORTS-1:0]            i_axis_TVALID,
    output logic [NUM_PORTS-1:0]            o_axis_TREADY,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_axis_TDATA,
    output logic                            o_axis_TVALID,
    input  logic                            i_axis_TREADY,
    output logic [DATA_WIDTH-1:0]           o_axis_TDATA,
    input  logic [NUM_PORTS-1:0]            i_port_en,
    output logic [NUM_PORTS-1:0]            o_grant,
    output logic                            o_busy,
    output logic [CNT_WIDTH-1:0]            o_frame_cnt
);

    localparam int unsigned IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned GAP_W  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam int unsigned BEAT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [NUM_PORTS-1:0]   r_grant;
    logic [IDX_W-1:0]       r_gidx;
    logic [IDX_W-1:0]       r_ptr;
    logic [BEAT_W-1:0]      r_beat_cnt;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic [CNT_WIDTH-1:0]   r_frame_cnt;
    logic                   r_busy;

    logic [NUM_PORTS-1:0]   w_req;
    logic                   w_found;
    logic [IDX_W-1:0]       w_sel_idx;
    logic                   w_g_valid;
    logic [DATA_WIDTH-1:0]  w_g_data;

    assign w_req = i_axis_TVALID & i_port_en;

    // Round-robin search starting just after the last granted port
    always_comb begin
        int unsigned cand;
        w_found   = 1'b0;
        w_sel_idx = r_ptr;
        cand      = 0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            cand = (32'(r_ptr) + i) % NUM_PORTS;
            if (!w_found && w_req[cand]) begin
                w_found   = 1'b1;
                w_sel_idx = IDX_W'(cand);
            end
        end
    end

    // Select the granted source's valid/data
    always_comb begin
        w_g_valid = 1'b0;
        w_g_data  = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (IDX_W'(k) == r_gidx) begin
                w_g_valid = i_axis_TVALID[k];
                w_g_data  = i_axis_TDATA[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Datapath mux; only the granted source sees downstream ready, only in XFER
    always_comb begin
        o_axis_TVALID = 1'b0;
        o_axis_TDATA  = w_g_data;
        o_axis_TREADY = '0;
        if (r_state == ST_XFER) begin
            o_axis_TVALID = w_g_valid;
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                if (IDX_W'(k) == r_gidx) begin
                    o_axis_TREADY[k] = i_axis_TREADY;
                end
            end
        end
    end

    // Arbitration FSM: grant in IDLE, hold for a frame in XFER, idle out the gap
    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_gidx      <= '0;
            r_ptr       <= IDX_W'(NUM_PORTS - 1);
            r_beat_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_frame_cnt <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_XFER;
                        r_grant <= NUM_PORTS'(1) << w_sel_idx;
                        r_gidx  <= w_sel_idx;
                        r_ptr   <= w_sel_idx;
                        r_busy  <= 1'b1;
                    end
                end
                ST_XFER: begin
                    if (!w_g_valid) begin
                        r_grant    <= '0;
                        r_beat_cnt <= '0;
                        if ((r_beat_cnt != '0) && (IFG_CYCLES > 0)) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                        if (r_beat_cnt != '0) begin
                            r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
                        end
                    end else if (i_axis_TREADY && (r_beat_cnt != '1)) begin
                        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_W'(IFG_CYCLES - 1)) begin
                        r_state   <= ST_IDLE;
                        r_gap_cnt <= '0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_grant     = r_grant;
    assign o_busy      = r_busy;
    assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_sakebi_ethernet_tx_arbiter.sv
// Directed bench for the TX frame arbiter: single source, contention,
// backpressure, enable mask, empty grant and reset mid-frame.
module tb_sakebi_ethernet_tx_arbiter;

    localparam int DW  = 8;
    localparam int NP  = 4;
    localparam int CW  = 16;

    logic              clk;
    logic              rst_n;
    logic [NP-1:0]     tvalid_in;
    logic [NP-1:0]     tready_out;
    logic [NP*DW-1:0]  tdata_in;
    logic              tvalid_out;
    logic              tready_in;
    logic [DW-1:0]     tdata_out;
    logic [NP-1:0]     port_en;
    logic [NP-1:0]     grant;
    logic              busy;
    logic [CW-1:0]     frame_cnt;

    sakebi_ethernet_tx_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_PORTS  (NP),
        .IFG_CYCLES (12),
        .CNT_WIDTH  (CW)
    ) u_dut (
        .i_axis_ACLK    (clk),
        .i_axis_ARESETn (rst_n),
        .i_axis_TVALID  (tvalid_in),
        .o_axis_TREADY  (tready_out),
        .i_axis_TDATA   (tdata_in),
        .o_axis_TVALID  (tvalid_out),
        .i_axis_TREADY  (tready_in),
        .o_axis_TDATA   (tdata_out),
        .i_port_en      (port_en),
        .o_grant        (grant),
        .o_busy         (busy),
        .o_frame_cnt    (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Source models: s_frames frames of s_len beats, data counts up from 0
    int s_frames [NP];
    int s_len    [NP];
    int s_left   [NP];
    int s_byte   [NP];
    bit s_drop   [NP];
    bit man;

    logic [DW-1:0] cap [$];
    logic [NP-1:0] g_log [$];
    int            g_start [$];
    int            g_end [$];
    int            cyc_n;
    logic [NP-1:0] prev_grant;
    bit            g1_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        for (int k = 0; k < NP; k++) begin
            tvalid_in[k] = (s_frames[k] > 0) && !s_drop[k];
            tdata_in[k*DW +: DW] = DW'(s_byte[k]);
        end
    endtask

    task automatic start_src(input int k, input int frames, input int len);
        s_frames[k] = frames;
        s_len[k]    = len;
        s_left[k]   = len;
        s_byte[k]   = 0;
        s_drop[k]   = 1'b0;
        drive_src();
    endtask

    task automatic clear_logs();
        cap.delete();
        g_log.delete();
        g_start.delete();
        g_end.delete();
        prev_grant = '0;
        g1_seen    = 1'b0;
    endtask

    // One clock: monitor at negedge, advance sources just after posedge
    task automatic cyc();
        logic [NP-1:0] beat;
        @(negedge clk);
        beat = tvalid_in & tready_out;
        if (tvalid_out && tready_in) cap.push_back(tdata_out);
        if (grant[1]) g1_seen = 1'b1;
        if (grant != '0 && prev_grant == '0) begin
            g_log.push_back(grant);
            g_start.push_back(cyc_n);
        end
        if (grant == '0 && prev_grant != '0) g_end.push_back(cyc_n);
        prev_grant = grant;
        @(posedge clk);
        #1;
        cyc_n++;
        if (!man) begin
            for (int k = 0; k < NP; k++) begin
                if (beat[k]) begin
                    s_byte[k]++;
                    s_left[k]--;
                    if (s_left[k] == 0) begin
                        s_frames[k]--;
                        s_drop[k] = 1'b1;
                        s_left[k] = s_len[k];
                    end
                end else begin
                    s_drop[k] = 1'b0;
                end
            end
            drive_src();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        man   = 1'b0;
        for (int k = 0; k < NP; k++) start_src(k, 0, 1);
        tready_in = 1'b1;
        port_en   = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            cyc();
            n++;
        end
        check(tag, 64'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        logic [NP-1:0] exp_order [6];
        rst_n     = 1'b0;
        tvalid_in = '0;
        tdata_in  = '0;
        tready_in = 1'b1;
        port_en   = '1;
        cyc_n     = 0;
        man       = 1'b0;

        // Reset state
        do_reset();
        check("rst_grant", 64'(grant), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_frame_cnt", 64'(frame_cnt), 0);
        check("rst_tvalid_out", 64'(tvalid_out), 0);
        check("rst_tready_out", 64'(tready_out), 0);

        // Single source: port 1, 60 beats
        start_src(1, 1, 60);
        #1;
        check("t1_grant_pre", 64'(grant), 0);
        cyc();
        check("t1_grant", 64'(grant), 64'h2);
        n = 0;
        while (tvalid_in[1] && n < 100) begin
            cyc();
            n++;
        end
        check("t1_src_done", 64'(tvalid_in[1]), 0);
        n = 0;
        while (busy && n < 40) begin
            cyc();
            n++;
        end
        check("t1_busy_fall_cycles", 64'(n), 13);
        check("t1_bytes", 64'(cap.size()), 60);
        bad = 0;
        foreach (cap[i]) if (cap[i] !== DW'(i)) bad++;
        check("t1_order", 64'(bad), 0);
        check("t1_frame_cnt", 64'(frame_cnt), 1);

        // Contention: ports 0,2,3 with two 10-beat frames each
        do_reset();
        start_src(0, 2, 10);
        start_src(2, 2, 10);
        start_src(3, 2, 10);
        n = 0;
        while ((g_log.size() < 6 || busy) && n < 500) begin
            cyc();
            n++;
        end
        check("t2_done", 64'(busy), 0);
        check("t2_ngrants", 64'(g_log.size()), 6);
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0100; exp_order[2] = 4'b1000;
        exp_order[3] = 4'b0001; exp_order[4] = 4'b0100; exp_order[5] = 4'b1000;
        for (int i = 0; i < 6; i++) begin
            if (i < g_log.size()) check($sformatf("t2_grant%0d", i), 64'(g_log[i]), 64'(exp_order[i]));
        end
        for (int i = 0; i < 5; i++) begin
            if (i + 1 < g_start.size() && i < g_end.size())
                check($sformatf("t2_idle_gap%0d", i), 64'(g_start[i+1] - g_end[i]), 13);
        end
        check("t2_bytes", 64'(cap.size()), 60);
        check("t2_frame_cnt", 64'(frame_cnt), 6);

        // Backpressure: port 0, 8 beats, downstream stalls on xfer cycles 3..5
        do_reset();
        start_src(0, 1, 8);
        cyc();
        check("t3_grant", 64'(grant), 64'h1);
        for (int c = 0; c < 40 && busy; c++) begin
            tready_in = !(c >= 3 && c <= 5);
            #1;
            if (c == 4) check("t3_tready_stall", 64'(tready_out), 0);
            if (c == 6) check("t3_tready_resume", 64'(tready_out), 64'h1);
            cyc();
        end
        tready_in = 1'b1;
        check("t3_done", 64'(busy), 0);
        check("t3_bytes", 64'(cap.size()), 8);
        bad = 0;
        foreach (cap[i]) if (cap[i] !== DW'(i)) bad++;
        check("t3_order", 64'(bad), 0);
        check("t3_frame_cnt", 64'(frame_cnt), 1);

        // Mask: port 1 disabled; port 2 loses its enable mid-frame
        do_reset();
        port_en = 4'b1101;
        start_src(1, 1, 5);
        start_src(2, 1, 10);
        cyc();
        check("t4_grant", 64'(grant), 64'h4);
        repeat (3) cyc();
        port_en = 4'b1001;
        wait_idle("t4_done", 60);
        repeat (20) cyc();
        check("t4_port1_never", 64'(g1_seen), 0);
        check("t4_ngrants", 64'(g_log.size()), 1);
        check("t4_bytes", 64'(cap.size()), 10);
        check("t4_frame_cnt", 64'(frame_cnt), 1);

        // Empty grant: port 3 pulses valid for one cycle with no ready
        do_reset();
        man = 1'b1;
        tready_in = 1'b0;
        tvalid_in = 4'b1000;
        cyc();
        check("t5_grant", 64'(grant), 64'h8);
        tvalid_in = '0;
        #1;
        check("t5_busy_xfer", 64'(busy), 1);
        cyc();
        check("t5_grant_clr", 64'(grant), 0);
        check("t5_busy_nogap", 64'(busy), 0);
        check("t5_frame_cnt", 64'(frame_cnt), 0);
        tready_in = 1'b1;
        tvalid_in = 4'b0001;
        cyc();
        check("t5_regrant", 64'(grant), 64'h1);
        tvalid_in = '0;
        cyc();
        man = 1'b0;

        // Reset mid-frame at beat 5 of port 2
        do_reset();
        start_src(2, 1, 10);
        cyc();
        check("t6_grant", 64'(grant), 64'h4);
        n = 0;
        while (cap.size() < 5 && n < 30) begin
            cyc();
            n++;
        end
        check("t6_beats_before_rst", 64'(cap.size()), 5);
        rst_n = 1'b0;
        #1;
        check("t6_rst_grant", 64'(grant), 0);
        check("t6_rst_tvalid_out", 64'(tvalid_out), 0);
        check("t6_rst_frame_cnt", 64'(frame_cnt), 0);
        check("t6_rst_busy", 64'(busy), 0);
        start_src(0, 1, 2);
        start_src(2, 1, 2);
        start_src(3, 1, 2);
        clear_logs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6_first_after_rst", 64'(grant), 64'h1);
        wait_idle("t6_done", 60);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
